vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//   Shares the single-port 8 KB VRAM between three requesters: LCD line fetcher, DMA engine, CPU.
//   Sits between the DMA engine's address/data bus and the VRAM macro; stalls the CPU via cpu_rdy.
//   One access per clock. Fixed priority LCD > DMA > CPU, plus an optional CPU anti-starvation slot.
// PARAMETERS
//   ADDR_W          13   VRAM address width (8 KB)
//   CPU_SLOT_EVERY  8    consecutive DMA grants (CPU waiting) before the CPU is forced a slot (guard only)
// PORTS
//   clk          in   1       system clock; all logic on posedge
//   reset        in   1       synchronous, active-high
//   lcd_req      in   1       LCD read request; hold with lcd_addr until lcd_ack
//   lcd_addr     in   ADDR_W  LCD read address
//   lcd_ack      out  1       LCD granted this cycle (combinational)
//   lcd_rvalid   out  1       rdata holds LCD read data
//   dma_req      in   1       DMA access request
//   dma_we       in   1       1: write, 0: read
//   dma_addr     in   ADDR_W  DMA address
//   dma_wdata    in   8       DMA write data
//   dma_ack      out  1       DMA granted this cycle (combinational)
//   dma_rvalid   out  1       rdata holds DMA read data
//   cpu_req      in   1       CPU access request
//   cpu_we       in   1       1: write, 0: read
//   cpu_addr     in   ADDR_W  CPU address
//   cpu_wdata    in   8       CPU write data
//   cpu_ack      out  1       CPU granted this cycle (combinational)
//   cpu_rvalid   out  1       rdata holds CPU read data
//   cpu_rdy      out  1       0 while cpu_req is high and not granted (CPU stall)
//   rdata        out  8       read data, shared by all requesters; qualify with *_rvalid
//   vram_addr    out  ADDR_W  registered VRAM address
//   vram_we      out  1       registered VRAM write strobe
//   vram_wdata   out  8       registered VRAM write data
//   vram_rdata   in   8       VRAM read data, 1 cycle after vram_addr
// BEHAVIOUR
//   - Cycle N: arbitrate among requests present at N. Exactly one *_ack (or none), combinational.
//   - Priority: lcd_req > dma_req > cpu_req; the guard slot (see CONFIGURATION) can promote CPU over DMA only.
//   - Edge N->N+1: winner's addr/we/wdata registered onto vram_*. With no winner, vram_we=0 and vram_addr holds its value.
//   - Read latency: winner's *_rvalid=1 in cycle N+2 with rdata=vram_rdata (combinational pass-through).
//     Owner tag pipelined 2 stages; writes produce no rvalid. LCD accesses are always reads (we forced 0).
//   - Requester drops or updates req/addr on the edge after its ack. req held high means a fresh request
//     (burst): back-to-back grants every cycle, one result per cycle.
//   - cpu_rdy = ~cpu_req | cpu_ack. An unacked request stays pending; no queueing inside the block.
//   - A request withdrawn before ack is dropped silently. Simultaneous requests: only the highest-priority
//     requester is acked; the others see ack=0 that cycle.
//   - Reset (including mid-transfer): vram_addr=0, vram_we=0, vram_wdata=0, all *_rvalid=0,
//     owner pipeline cleared (in-flight read results discarded), guard counter=0.
//     *_ack=0 and cpu_rdy=~cpu_req while reset is high.
// CONFIGURATION
//   VRAM_CPU_GUARD_EN defined: 4-bit counter run_cnt counts DMA grants in cycles where cpu_req=1 and CPU not acked.
//     When run_cnt==CPU_SLOT_EVERY and cpu_req=1 and lcd_req=0, CPU wins over DMA.
//     run_cnt clears on any cpu_ack or when cpu_req=0. Saturates; never wraps.
//   VRAM_CPU_GUARD_EN undefined: strict priority. CPU may starve for the full DMA burst. run_cnt is not built.
// TESTING
//   1. CPU write 0x1234<=0xA5, then read 0x1234 -> cpu_ack both cycles; cpu_rvalid 2 cycles after read ack; rdata=0xA5.
//   2. lcd_req, dma_req, cpu_req all high in one cycle -> only lcd_ack=1; next cycle dma_ack; CPU after DMA drops;
//      cpu_rdy=0 until cpu_ack.
//   3. DMA 16-byte read burst 0x0000..0x000F, req held -> 16 consecutive dma_ack; dma_rvalid on 16 consecutive
//      cycles; rdata matches preloaded bytes in order.
//   4. Guard on, CPU_SLOT_EVERY=8, DMA burst of 20 plus CPU read -> cpu_ack in the cycle after the 8th DMA grant.
//      Guard off: cpu_ack after the 20th.
//   5. Assert reset one cycle after a DMA read ack -> no dma_rvalid; vram_we=0, vram_addr=0; first post-reset
//      request acked in its first cycle.
//   6. LCD read at 0x1FFF interleaved with CPU write at 0x1FFF in the next cycle -> LCD gets old data,
//      later CPU read returns new data.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Shares one single-port 8 KB VRAM between the LCD line fetcher,
//             the DMA engine and the CPU. One access per clock, fixed
//             priority LCD > DMA > CPU. The winner's access is registered
//             onto the VRAM bus; read data comes back two cycles after the
//             grant and is tagged for its owner with *_rvalid.
//  Options  : VRAM_CPU_GUARD_EN - when defined, the CPU is forced a slot
//             after CPU_SLOT_EVERY consecutive DMA grants while it waits.
//  Ports    : clk, reset (sync, active-high)
//             lcd_req/lcd_addr -> lcd_ack, lcd_rvalid
//             dma_req/dma_we/dma_addr/dma_wdata -> dma_ack, dma_rvalid
//             cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack, cpu_rvalid, cpu_rdy
//             rdata (shared read data)
//             vram_addr/vram_we/vram_wdata -> VRAM macro, vram_rdata <- VRAM
//  Revision : 1.0  initial release
// ============================================================================
module vram_arbiter #(
   parameter int ADDR_W         = 13,
   parameter int CPU_SLOT_EVERY = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lcd_req,
   input  logic [ADDR_W-1:0] lcd_addr,
   output logic              lcd_ack,
   output logic              lcd_rvalid,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [7:0]        dma_wdata,
   output logic              dma_ack,
   output logic              dma_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic              cpu_rdy,
   output logic [7:0]        rdata,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [7:0]        vram_wdata,
   input  logic [7:0]        vram_rdata
);

   // Owner tag bit positions: {lcd, dma, cpu}
   localparam int c_OWN_LCD = 2;
   localparam int c_OWN_DMA = 1;
   localparam int c_OWN_CPU = 0;

   logic              w_gnt_lcd;
   logic              w_gnt_dma;
   logic              w_gnt_cpu;
   logic              w_cpu_force;

   logic [ADDR_W-1:0] r_vram_addr;
   logic              r_vram_we;
   logic [7:0]        r_vram_wdata;
   // Read-owner pipeline: stage 1 lines up with vram_addr, stage 2 with vram_rdata
   logic [2:0]        r_own1;
   logic [2:0]        r_own2;

`ifdef VRAM_CPU_GUARD_EN
   localparam logic [3:0] c_SLOT = 4'(CPU_SLOT_EVERY);

   // Counts DMA grants taken while the CPU sits waiting. Only DMA grants
   // advance it, and at c_SLOT the CPU takes the next non-LCD slot, so in
   // practice it tops out at c_SLOT; the saturation is a safety net.
   logic [3:0] r_run_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_run_cnt <= 4'd0;
      end else if (!cpu_req || w_gnt_cpu) begin
         r_run_cnt <= 4'd0;
      end else if (w_gnt_dma && (r_run_cnt != 4'hF)) begin
         r_run_cnt <= r_run_cnt + 4'd1;
      end
   end

   assign w_cpu_force = cpu_req & ~lcd_req & (r_run_cnt == c_SLOT);
`else
   assign w_cpu_force = 1'b0;
`endif

   // Grant decode. Acks are suppressed while reset is high so nothing is
   // told it was served in a cycle whose access the registers will drop.
   always_comb begin
      w_gnt_lcd = 1'b0;
      w_gnt_dma = 1'b0;
      w_gnt_cpu = 1'b0;
      if (!reset) begin
         if (lcd_req) begin
            w_gnt_lcd = 1'b1;
         end else if (w_cpu_force) begin
            w_gnt_cpu = 1'b1;
         end else if (dma_req) begin
            w_gnt_dma = 1'b1;
         end else if (cpu_req) begin
            w_gnt_cpu = 1'b1;
         end
      end
   end

   assign lcd_ack = w_gnt_lcd;
   assign dma_ack = w_gnt_dma;
   assign cpu_ack = w_gnt_cpu;
   assign cpu_rdy = ~cpu_req | w_gnt_cpu;

   // VRAM bus register and owner pipeline. With no winner the address and
   // write data hold, only the write strobe drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vram_addr  <= '0;
         r_vram_we    <= 1'b0;
         r_vram_wdata <= 8'd0;
         r_own1       <= 3'b000;
         r_own2       <= 3'b000;
      end else begin
         r_own2 <= r_own1;
         if (w_gnt_lcd) begin
            r_vram_addr <= lcd_addr;
            r_vram_we   <= 1'b0;
            r_own1      <= 3'b100;
         end else if (w_gnt_dma) begin
            r_vram_addr  <= dma_addr;
            r_vram_we    <= dma_we;
            r_vram_wdata <= dma_wdata;
            r_own1       <= {1'b0, ~dma_we, 1'b0};
         end else if (w_gnt_cpu) begin
            r_vram_addr  <= cpu_addr;
            r_vram_we    <= cpu_we;
            r_vram_wdata <= cpu_wdata;
            r_own1       <= {2'b00, ~cpu_we};
         end else begin
            r_vram_we <= 1'b0;
            r_own1    <= 3'b000;
         end
      end
   end

   assign vram_addr  = r_vram_addr;
   assign vram_we    = r_vram_we;
   assign vram_wdata = r_vram_wdata;

   assign lcd_rvalid = r_own2[c_OWN_LCD];
   assign dma_rvalid = r_own2[c_OWN_DMA];
   assign cpu_rvalid = r_own2[c_OWN_CPU];
   assign rdata      = vram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Directed self-checking bench for vram_arbiter with a
//             read-first synchronous VRAM model (1-cycle read latency).
//             Expectations for the guard-slot test follow VRAM_CPU_GUARD_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;

   localparam int ADDR_W = 13;

   logic              clk;
   logic              reset;
   logic              lcd_req;
   logic [ADDR_W-1:0] lcd_addr;
   logic              lcd_ack;
   logic              lcd_rvalid;
   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [7:0]        dma_wdata;
   logic              dma_ack;
   logic              dma_rvalid;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_ack;
   logic              cpu_rvalid;
   logic              cpu_rdy;
   logic [7:0]        rdata;
   logic [ADDR_W-1:0] vram_addr;
   logic              vram_we;
   logic [7:0]        vram_wdata;
   logic [7:0]        vram_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   vram_arbiter #(.ADDR_W(ADDR_W), .CPU_SLOT_EVERY(8)) dut (
      .clk(clk), .reset(reset),
      .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_ack(lcd_ack), .lcd_rvalid(lcd_rvalid),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rvalid(dma_rvalid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdy(cpu_rdy),
      .rdata(rdata),
      .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
      .vram_rdata(vram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Preload pattern for the VRAM model
   function automatic logic [7:0] pat(input int a);
      return 8'((a * 37 + 11) & 255);
   endfunction

   // VRAM model: read-first, data one cycle after the address. Contents are
   // reloaded with the pattern whenever reset is high.
   logic [7:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      vram_rdata <= mem[vram_addr];
      if (reset) begin
         for (int a = 0; a < (1 << ADDR_W); a++) mem[a] <= pat(a);
      end else if (vram_we) begin
         mem[vram_addr] <= vram_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      lcd_req = 1'b0; lcd_addr = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = 8'd0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'd0;
   endtask

   // Advance to the middle of the next cycle (inputs get set right after)
   task automatic next();
      @(negedge clk);
   endtask

   int cpu_cycle;
   int dma_cnt;
   int dma_at_cpu;
   int exp_slot;

   initial begin
      idle();
      reset = 1'b1;
      next(); next();
      #1;
      // Reset state
      check("rst_vram_we",   32'(vram_we), 0);
      check("rst_vram_addr", 32'(vram_addr), 0);
      check("rst_rvalid",    32'({lcd_rvalid, dma_rvalid, cpu_rvalid}), 0);
      cpu_req = 1'b1;
      #1;
      check("rst_acks",    32'({lcd_ack, dma_ack, cpu_ack}), 0);
      check("rst_cpu_rdy", 32'(cpu_rdy), 0);
      next();
      reset = 1'b0;
      idle();

      // ---- 1: CPU write then read back -----------------------------------
      next();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1234; cpu_wdata = 8'hA5;
      #1 check("t1_wr_ack", 32'(cpu_ack), 1);
      check("t1_wr_rdy", 32'(cpu_rdy), 1);
      next();
      cpu_we = 1'b0;
      #1 check("t1_rd_ack", 32'(cpu_ack), 1);
      next();
      idle();
      #1 check("t1_wr_no_rvalid", 32'(cpu_rvalid), 0);
      next();
      #1 check("t1_rvalid", 32'(cpu_rvalid), 1);
      check("t1_rdata", 32'(rdata), 32'h0A5);
      next();

      // ---- 2: simultaneous requests ---------------------------------------
      next();
      lcd_req = 1'b1; lcd_addr = 13'h0100;
      dma_req = 1'b1; dma_addr = 13'h0200;
      cpu_req = 1'b1; cpu_addr = 13'h0300;
      #1 check("t2_c0_acks", 32'({lcd_ack, dma_ack, cpu_ack}), 32'b100);
      check("t2_c0_rdy", 32'(cpu_rdy), 0);
      next();
      lcd_req = 1'b0;
      #1 check("t2_c1_acks", 32'({lcd_ack, dma_ack, cpu_ack}), 32'b010);
      check("t2_c1_rdy", 32'(cpu_rdy), 0);
      next();
      dma_req = 1'b0;
      #1 check("t2_c2_acks", 32'({lcd_ack, dma_ack, cpu_ack}), 32'b001);
      check("t2_c2_rdy", 32'(cpu_rdy), 1);
      check("t2_lcd_rvalid", 32'({lcd_rvalid, dma_rvalid, cpu_rvalid}), 32'b100);
      check("t2_lcd_rdata", 32'(rdata), 32'(pat(32'h100)));
      next();
      idle();
      #1 check("t2_dma_rvalid", 32'({lcd_rvalid, dma_rvalid, cpu_rvalid}), 32'b010);
      check("t2_dma_rdata", 32'(rdata), 32'(pat(32'h200)));
      next();
      #1 check("t2_cpu_rvalid", 32'({lcd_rvalid, dma_rvalid, cpu_rvalid}), 32'b001);
      check("t2_cpu_rdata", 32'(rdata), 32'(pat(32'h300)));

      // ---- 3: 16-byte DMA read burst --------------------------------------
      for (int i = 0; i < 19; i++) begin
         next();
         dma_req  = (i < 16);
         dma_addr = (i < 16) ? 13'(i) : '0;
         #1;
         if (i < 16) check($sformatf("t3_ack%0d", i), 32'(dma_ack), 1);
         if (i >= 2 && i < 18) begin
            check($sformatf("t3_rvalid%0d", i - 2), 32'(dma_rvalid), 1);
            check($sformatf("t3_rdata%0d", i - 2), 32'(rdata), 32'(pat(i - 2)));
         end else begin
            check($sformatf("t3_no_rvalid_c%0d", i), 32'(dma_rvalid), 0);
         end
      end
      idle();

      // ---- 4: DMA burst of 20 with a waiting CPU read ---------------------
`ifdef VRAM_CPU_GUARD_EN
      exp_slot = 8;
`else
      exp_slot = 20;
`endif
      cpu_cycle  = -1;
      dma_cnt    = 0;
      dma_at_cpu = -1;
      for (int c = 0; c < 30; c++) begin
         next();
         dma_req  = (dma_cnt < 20);
         dma_addr = 13'(32'h20 + dma_cnt);
         cpu_req  = (cpu_cycle < 0);
         cpu_addr = 13'h0300;
         #1;
         if (c == 0) check("t4_rdy_stall", 32'(cpu_rdy), 0);
         if (cpu_ack && cpu_cycle < 0) begin
            cpu_cycle  = c;
            dma_at_cpu = dma_cnt;
         end
         if (dma_ack) dma_cnt++;
      end
      check("t4_cpu_cycle", 32'(cpu_cycle), 32'(exp_slot));
      check("t4_dma_before_cpu", 32'(dma_at_cpu), 32'(exp_slot));
      check("t4_dma_total", 32'(dma_cnt), 20);
      idle();
      next(); next(); next();

      // ---- 5: reset one cycle after a DMA read ack ------------------------
      next();
      dma_req = 1'b1; dma_addr = 13'h0005;
      #1 check("t5_dma_ack", 32'(dma_ack), 1);
      next();
      dma_req = 1'b0;
      reset   = 1'b1;
      cpu_req = 1'b1; cpu_addr = 13'h0300;
      #1 check("t5_rst_cpu_ack", 32'(cpu_ack), 0);
      check("t5_rst_cpu_rdy", 32'(cpu_rdy), 0);
      next();
      reset = 1'b0;
      #1 check("t5_no_rvalid", 32'(dma_rvalid), 0);
      check("t5_vram_we", 32'(vram_we), 0);
      check("t5_vram_addr", 32'(vram_addr), 0);
      check("t5_first_ack", 32'(cpu_ack), 1);
      next();
      idle();
      #1 check("t5_no_rvalid2", 32'(dma_rvalid), 0);
      next();
      #1 check("t5_cpu_rvalid", 32'(cpu_rvalid), 1);
      check("t5_cpu_rdata", 32'(rdata), 32'(pat(32'h300)));

      // ---- 6: LCD read then CPU write/read at 0x1FFF ----------------------
      next();
      lcd_req = 1'b1; lcd_addr = 13'h1FFF;
      #1 check("t6_lcd_ack", 32'(lcd_ack), 1);
      next();
      lcd_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'h3C;
      #1 check("t6_wr_ack", 32'(cpu_ack), 1);
      next();
      cpu_we = 1'b0;
      #1 check("t6_rd_ack", 32'(cpu_ack), 1);
      check("t6_lcd_rvalid", 32'(lcd_rvalid), 1);
      check("t6_lcd_old", 32'(rdata), 32'(pat(32'h1FFF)));
      next();
      idle();
      next();
      #1 check("t6_cpu_rvalid", 32'(cpu_rvalid), 1);
      check("t6_cpu_new", 32'(rdata), 32'h3C);

      next();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
